// File: rtl/expr_seq_pkg.sv
// Shared types and constants for the expression-block vector sequencer and signature checkers.
package expr_seq_pkg;

  // Operand vector width (a_bus + b_bus) and DUT result width
  localparam int unsigned OPW  = 60;
  localparam int unsigned RESW = 90;

  // Bus slices within the operand vector: {a_bus, b_bus}
  localparam int unsigned BusW    = 30;
  localparam int unsigned ABusLsb = 30;
  localparam int unsigned BBusLsb = 0;

  // Feedback tap masks: LFSR x^60+x^59+1, MISR taps on the top four bits
  localparam logic [OPW-1:0]  LfsrTaps = {2'b11, 58'h0};
  localparam logic [RESW-1:0] MisrTaps = {4'hf, 86'h0};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } seq_state_e;

  // One Fibonacci shift of the operand LFSR
  function automatic logic [OPW-1:0] lfsr_step(input logic [OPW-1:0] s);
    return {s[OPW-2:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/expr_misr.sv
// Multiple-input signature register with synchronous clear and capture enable.
module expr_misr
  import expr_seq_pkg::*;
#(
  parameter int unsigned      Width = RESW,
  parameter logic [Width-1:0] Taps  = MisrTaps
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] sig_o
);

  logic [Width-1:0] sig_q, sig_d;

  // Next signature: clear wins over capture; otherwise hold
  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = {sig_q[Width-2:0], ^(sig_q & Taps)} ^ data_i;
    end
  end

  // Signature register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/expr_vector_sequencer.sv
// Drives pseudo-random operand vectors into an expression DUT and folds its results into a MISR.
module expr_vector_sequencer
  import expr_seq_pkg::*;
#(
  parameter int unsigned    NVEC    = 256,
  parameter logic [OPW-1:0] SEED    = 60'h1,
  parameter int unsigned    DUT_LAT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [BusW-1:0] a_bus,
  output logic [BusW-1:0] b_bus,
  input  logic [RESW-1:0] y_in,
  output logic            busy,
  output logic            done,
  output logic [RESW-1:0] signature,
  output logic [15:0]     vec_count
);

  localparam logic [15:0] LastIssue = 16'(NVEC);

  seq_state_e     state_q;
  logic [OPW-1:0] lfsr_q;
  logic [OPW-1:0] bus_q;
  logic [15:0]    issue_q;
  logic [15:0]    vec_count_q;
  logic [2:0]     drain_q;
  logic           busy_q;
  logic           done_q;
  logic           bus_vld_q;
  logic           go;
  logic           cap_vld;
  logic           cap_en;

  assign go     = (state_q == StIdle) && start && !abort;
  assign cap_en = cap_vld && !abort;

  // FSM, operand LFSR, bus register and issue/drain counters. RUN spans NVEC+1 cycles because
  // the last vector still needs its bus cycle before capture can complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lfsr_q    <= '0;
      bus_q     <= '0;
      issue_q   <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bus_vld_q <= 1'b0;
    end else begin
      bus_vld_q <= 1'b0;
      done_q    <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (go) begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              lfsr_q  <= SEED;
              issue_q <= '0;
            end
          end
          StRun: begin
            if (issue_q != LastIssue) begin
              bus_q     <= lfsr_q;
              bus_vld_q <= 1'b1;
              lfsr_q    <= lfsr_step(lfsr_q);
              issue_q   <= issue_q + 16'd1;
            end else if (DUT_LAT != 0) begin
              state_q <= StDrain;
              drain_q <= 3'(DUT_LAT - 1);
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          StDrain: begin
            if (drain_q == 3'd0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              drain_q <= drain_q - 3'd1;
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  // Valid bit follows each presented vector through the DUT latency
  if (DUT_LAT == 0) begin : g_nolat
    assign cap_vld = bus_vld_q;
  end else begin : g_lat
    localparam int unsigned PipeW = DUT_LAT;
    logic [PipeW-1:0] vpipe_q;

    // Delay line for the capture valid; abort flushes in-flight vectors
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vpipe_q <= '0;
      end else if (abort) begin
        vpipe_q <= '0;
      end else begin
        vpipe_q <= (vpipe_q << 1) | PipeW'(bus_vld_q);
      end
    end

    assign cap_vld = vpipe_q[PipeW-1];
  end

  // Count of vectors absorbed into the signature
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count_q <= '0;
    end else if (go) begin
      vec_count_q <= '0;
    end else if (cap_en) begin
      vec_count_q <= vec_count_q + 16'd1;
    end
  end

  expr_misr #(
    .Width (RESW),
    .Taps  (MisrTaps)
  ) u_misr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (go),
    .en_i   (cap_en),
    .data_i (y_in),
    .sig_o  (signature)
  );

  assign a_bus     = bus_q[ABusLsb +: BusW];
  assign b_bus     = bus_q[BBusLsb +: BusW];
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Bench for expr_vector_sequencer: four instances (NVEC 1/4/16, DUT_LAT 0/3) run from a table,
// with a reference LFSR/MISR model feeding a scoreboard of expected run results.
module tb_expr_vector_sequencer;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_s [NI];
  logic        abort_s [NI];
  int          mode_s  [NI];
  logic [29:0] a_s     [NI];
  logic [29:0] b_s     [NI];
  logic [89:0] y_s     [NI];
  logic [89:0] sig_s   [NI];
  logic        busy_s  [NI];
  logic        done_s  [NI];
  logic [15:0] cnt_s   [NI];

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int          inst;
    int          mode;
    int          abort_at;
    int          busy_start_at;
    bit          use_const;
    logic [89:0] csig;
  } run_t;

  typedef struct {
    logic [89:0] sig;
    logic [15:0] cnt;
    int          done_c;
  } exp_t;

  exp_t        sb[$];
  logic [59:0] vq[$];
  run_t        runs[9];

  // Stand-in expression DUT result as a function of the operand buses
  function automatic logic [89:0] y_func(input int m, input logic [29:0] a, input logic [29:0] b);
    case (m)
      0:       return '0;
      1:       return '1;
      2:       return {30'b0, a, b};
      default: return {a ^ {b[14:0], b[29:15]}, a + b, a & ~b};
    endcase
  endfunction

  function automatic logic [59:0] lfsr_next(input logic [59:0] v);
    return {v[58:0], v[59] ^ v[58]};
  endfunction

  function automatic logic [89:0] misr_next(input logic [89:0] s, input logic [89:0] y);
    return {s[88:0], s[89] ^ s[88] ^ s[87] ^ s[86]} ^ y;
  endfunction

  function automatic int nvec_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
  endfunction

  function automatic int lat_of(input int i);
    return (i == 3) ? 3 : 0;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [89:0] y_comb;
    assign y_comb = y_func(mode_s[g], a_s[g], b_s[g]);
    if (g == 3) begin : g_pipe
      logic [89:0] p1 = '0;
      logic [89:0] p2 = '0;
      logic [89:0] p3 = '0;
      always @(posedge clk) begin
        p1 <= y_comb;
        p2 <= p1;
        p3 <= p2;
      end
      assign y_s[g] = p3;
    end else begin : g_comb
      assign y_s[g] = y_comb;
    end

    expr_vector_sequencer #(
      .NVEC    ((g == 0) ? 1 : ((g == 1) ? 4 : 16)),
      .SEED    (60'h1),
      .DUT_LAT ((g == 3) ? 3 : 0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_s[g]),
      .abort     (abort_s[g]),
      .a_bus     (a_s[g]),
      .b_bus     (b_s[g]),
      .y_in      (y_s[g]),
      .busy      (busy_s[g]),
      .done      (done_s[g]),
      .signature (sig_s[g]),
      .vec_count (cnt_s[g])
    );
  end

  task automatic check(input string name, input logic [89:0] got, input logic [89:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int i);
    check($sformatf("%s a_bus[%0d]", tag, i), 90'(a_s[i]), '0);
    check($sformatf("%s b_bus[%0d]", tag, i), 90'(b_s[i]), '0);
    check($sformatf("%s busy[%0d]", tag, i), 90'(busy_s[i]), '0);
    check($sformatf("%s done[%0d]", tag, i), 90'(done_s[i]), '0);
    check($sformatf("%s signature[%0d]", tag, i), sig_s[i], '0);
    check($sformatf("%s vec_count[%0d]", tag, i), 90'(cnt_s[i]), '0);
  endtask

  // One table run: model pushes expectations, the run loop pops and compares them
  task automatic run_one(input int idx, input run_t r);
    int          n;
    int          lat;
    int          ncap;
    int          got_done;
    int          limit;
    logic [59:0] v;
    logic [59:0] ev;
    logic [89:0] s;
    exp_t        e;

    n    = nvec_of(r.inst);
    lat  = lat_of(r.inst);
    ncap = (r.abort_at > 0) ? r.abort_at - 1 : n;
    v    = 60'h1;
    s    = '0;
    for (int k = 0; k < n; k++) begin
      vq.push_back(v);
      if (k < ncap) s = misr_next(s, y_func(r.mode, v[59:30], v[29:0]));
      v = lfsr_next(v);
    end
    e.sig    = r.use_const ? r.csig : s;
    e.cnt    = 16'(ncap);
    e.done_c = (r.abort_at > 0) ? -1 : n + lat + 1;
    sb.push_back(e);

    mode_s[r.inst]  = r.mode;
    start_s[r.inst] = 1'b1;
    @(posedge clk);
    #1;
    start_s[r.inst] = 1'b0;
    check($sformatf("run%0d busy after start", idx), 90'(busy_s[r.inst]), 90'(1));

    got_done = -1;
    limit    = n + lat + 6;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      if (c <= n && (r.abort_at == 0 || c <= r.abort_at)) begin
        ev = vq.pop_front();
        check($sformatf("run%0d vector%0d", idx, c - 1), 90'({a_s[r.inst], b_s[r.inst]}),
              90'(ev));
      end
      if (done_s[r.inst] && got_done < 0) begin
        got_done = c;
        check($sformatf("run%0d busy at done", idx), 90'(busy_s[r.inst]), '0);
      end
      if (got_done >= 0) break;
      start_s[r.inst] = (c == r.busy_start_at);
      abort_s[r.inst] = (c == r.abort_at);
    end
    start_s[r.inst] = 1'b0;
    abort_s[r.inst] = 1'b0;
    vq.delete();

    e = sb.pop_front();
    check($sformatf("run%0d done cycle", idx), 90'(got_done), 90'(e.done_c));
    check($sformatf("run%0d signature", idx), sig_s[r.inst], e.sig);
    check($sformatf("run%0d vec_count", idx), 90'(cnt_s[r.inst]), 90'(e.cnt));

    @(posedge clk);
    #1;
    check($sformatf("run%0d signature held", idx), sig_s[r.inst], e.sig);
    check($sformatf("run%0d idle busy", idx), 90'(busy_s[r.inst]), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1);
  end

  initial begin
    runs[0] = '{0, 0, 0, 0, 1'b1, 90'h0};
    runs[1] = '{0, 1, 0, 0, 1'b1, 90'h3FF_FFFF_FFFF_FFFF_FFFF_FFFF};
    runs[2] = '{0, 1, 0, 0, 1'b1, 90'h3FF_FFFF_FFFF_FFFF_FFFF_FFFF};
    runs[3] = '{1, 2, 0, 0, 1'b0, 90'h0};
    runs[4] = '{2, 3, 0, 0, 1'b0, 90'h0};
    runs[5] = '{3, 3, 0, 0, 1'b0, 90'h0};
    runs[6] = '{2, 3, 6, 0, 1'b0, 90'h0};
    runs[7] = '{2, 3, 0, 0, 1'b0, 90'h0};
    runs[8] = '{3, 3, 0, 3, 1'b0, 90'h0};

    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      mode_s[i]  = 0;
    end

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check_idle_outputs("reset", i);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) run_one(i, runs[i]);

    // Asynchronous reset in the middle of a run
    mode_s[2]  = 3;
    start_s[2] = 1'b1;
    @(posedge clk);
    #1;
    start_s[2] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrun busy before reset", 90'(busy_s[2]), 90'(1));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrun reset", 2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset stays idle", 90'(busy_s[2]), '0);

    run_one(9, runs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/expr_vector_sequencer.md
# expr_vector_sequencer

Self-checking stimulus/response controller for the combinational expression blocks in the regression suite. It generates pseudo-random operand vectors for the twelve DUT operand inputs a0..a5 and b0..b5, issuing one vector per cycle. It compresses the 90-bit DUT result `y` into a MISR signature. The bench compares that signature against the golden value from the simulator run of the same expression.

## Interface
- `NVEC`, 256: number of vectors issued per run (1..65535).
- `SEED`, 60'h0000_0000_0000_001: LFSR load value at start (must be nonzero).
- `DUT_LAT`, 0: DUT pipeline latency in cycles (0..7); 0 means purely combinational.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  return to IDLE from any state; takes priority over `start`.
- `a_bus`  out  30  {a0[3:0],a1[4:0],a2[5:0],a3[3:0],a4[4:0],a5[5:0]}, registered.
- `b_bus`  out  30  {b0..b5}, same packing, registered.
- `y_in`  in  90  DUT result {y0..y17}.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse on entry to DONE.
- `signature`  out  90  MISR value; held until the next `start`.
- `vec_count`  out  16  number of vectors captured into the MISR.

## Operation
- Operand LFSR is 60-bit Fibonacci, polynomial x^60+x^59+1.
  - Shift step: lfsr <= {lfsr[58:0], lfsr[59]^lfsr[58]}.
  - {a_bus,b_bus} = lfsr.
- States and transitions:
  - IDLE: on `start` (and no `abort`) → RUN. On the same edge: lfsr <= SEED, signature <= 0, vec_count <= 0, issue counter <= 0.
  - RUN: each cycle presents lfsr on the buses, then steps the LFSR and increments the issue counter. After the NVEC-th vector is presented → DRAIN if DUT_LAT>0, else → DONE.
  - DRAIN: lasts exactly DUT_LAT cycles, then → DONE.
  - DONE: one cycle; `done`=1; → IDLE.
- Capture pipeline:
  - A valid bit enters a DUT_LAT-deep shift register with each presented vector.
  - When the delayed valid bit is 1, the MISR absorbs `y_in` at that edge and vec_count increments.
- MISR rule: sig <= {sig[88:0], sig[89]^sig[88]^sig[87]^sig[86]} ^ y_in.
- Buses hold their last value in DRAIN, DONE and IDLE.
- Reset clears the buses to 0.
- `abort` in any state → IDLE next edge.
  - Valid pipeline is flushed.
  - `signature` and `vec_count` freeze at their current values; no `done`.
- `start` while busy is ignored.
- Reset asserted mid-run: immediate return to IDLE, all registers cleared.

## Timing
- Reset values: state IDLE, busy 0, done 0, a_bus 0, b_bus 0, signature 0, vec_count 0.
- Start sampled at edge E0. Vector k (k=0..NVEC-1) is on the buses during cycle E0+1+k.
- Vector k is captured at edge E0+2+k+DUT_LAT.
- `done` is high in cycle E0+1+NVEC+DUT_LAT. `signature` is final in that cycle.
- Throughput: 1 vector/cycle. Run length: NVEC+DUT_LAT+1 cycles from start to done.
- `busy` falls in the same cycle `done` rises.

## Structure
- Shared package `expr_seq_pkg` holds:
  - state enum {IDLE,RUN,DRAIN,DONE};
  - widths OPW=60 and RESW=90;
  - LFSR and MISR tap constants;
  - the a/b bus slice offsets.
- Sub-module `expr_misr` (RESW-bit MISR with clear, enable and data ports) is shared with other signature checkers.
- LFSR, counters and FSM live in the top module.

## Test plan
- NVEC=1, SEED=1, DUT_LAT=0, y_in=0: a_bus=0, b_bus=1 in cycle E0+1; done in cycle E0+2; signature=0; vec_count=1.
- NVEC=1, y_in=all-ones: signature=90'h3FF_FFFF_FFFF_FFFF_FFFF_FFFF; a second run clears the signature and reproduces the same value.
- NVEC=4, SEED=1, y_in = {30'b0, a_bus, b_bus}: successive vectors on {a_bus,b_bus} are 60'h1, 60'h2, 60'h4, 60'h8; signature matches the reference-model MISR.
- DUT_LAT=3 with a 3-stage registered DUT model, NVEC=16: signature equals the DUT_LAT=0 run on the combinational model; done occurs 3 cycles later.
- `abort` at issue cycle 5 of NVEC=16: IDLE next edge; vec_count=5; done never pulses; a following `start` completes with vec_count=16.
- `rst_n` low for 1 cycle mid-RUN: all outputs 0 asynchronously; `start` while busy (cycle E0+3) has no effect on vector order.
